// File: rtl/jts16_rom_slot.sv
// jts16_rom_slot: single-client SDRAM read slot with a 2-entry cache; hits
// answer in one cycle, misses run one req/ack/dst/rdy fill at a time.
module jts16_rom_slot #(
    parameter int          DW     = 32,
    parameter int          AW     = 17,
    parameter logic [21:0] OFFSET = 22'd0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr,
    input  logic          cs,
    input  logic          clr,
    output logic [DW-1:0] dout,
    output logic          ok,
    output logic [21:0]   sdram_addr,
    output logic          sdram_req,
    input  logic          sdram_ack,
    input  logic          data_dst,
    input  logic          data_rdy,
    input  logic [15:0]   data_read
);
    localparam int TW = DW == 8 ? AW - 1 : AW;
    localparam int CW = DW == 32 ? 32 : 16;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HIGH} state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      fill_tag_q, fill_tag_d, tag;
    logic [15:0]        low_q, low_d;
    logic [1:0][TW-1:0] tag_q, tag_d;
    logic [1:0][CW-1:0] data_q, data_d;
    logic [1:0]         valid_q, valid_d;
    logic               victim_q, victim_d, poison_q, poison_d, ok_r_q, ok_r_d;
    logic [DW-1:0]      dout_q, dout_d;
    logic [AW-1:0]      ok_addr_q, ok_addr_d;
    logic               hit0, hit1, fill_done, fill_ok;
    logic [CW-1:0]      fill_data;

    function automatic logic [DW-1:0] pick(input logic [CW-1:0] d, input logic b);
        return DW == 8 ? DW'(b ? d[15:8] : d[7:0]) : DW'(d);
    endfunction

    assign tag        = addr[AW-1:AW-TW];
    assign hit0       = valid_q[0] && tag_q[0] == tag;
    assign hit1       = valid_q[1] && tag_q[1] == tag;
    assign fill_done  = data_rdy && (state_q == HIGH || (state_q == WAIT && DW != 32));
    assign fill_data  = CW'(DW == 32 ? {data_read, low_q} : {16'd0, data_read});
    // a fill overlapped by clr still completes the handshake but is never used
    assign fill_ok    = fill_done && !poison_q && !clr;
    assign sdram_req  = state_q == REQ;
    assign sdram_addr = (DW == 32 ? 22'({fill_tag_q, 1'b0}) : 22'(fill_tag_q)) + OFFSET;
    assign dout       = dout_q;
    assign ok         = cs && ok_r_q && addr == ok_addr_q;

    always_comb begin
        state_d    = state_q;
        fill_tag_d = fill_tag_q;
        low_d      = low_q;
        tag_d      = tag_q;
        data_d     = data_q;
        valid_d    = valid_q;
        victim_d   = victim_q;
        poison_d   = poison_q;
        ok_r_d     = ok_r_q;
        dout_d     = dout_q;
        ok_addr_d  = ok_addr_q;
        if (state_q == IDLE && cs && !hit0 && !hit1) begin
            state_d    = REQ;
            fill_tag_d = tag;
            poison_d   = 1'b0;
        end
        if (state_q == REQ && sdram_ack) state_d = WAIT;
        if (state_q == WAIT && data_dst) begin
            low_d   = data_read;
            state_d = DW == 32 ? HIGH : state_q;
        end
        if (clr && state_q != IDLE) poison_d = 1'b1;
        if (cs) begin
            ok_r_d    = hit0 || hit1;
            dout_d    = hit0 ? pick(data_q[0], addr[0]) : hit1 ? pick(data_q[1], addr[0]) : dout_q;
            ok_addr_d = addr;
        end
        if (fill_done) begin
            state_d           = IDLE;
            victim_d          = !victim_q;
            tag_d[victim_q]   = fill_tag_q;
            data_d[victim_q]  = fill_data;
            valid_d[victim_q] = !poison_q;
        end
        // a fill for the address being asked for answers straight away
        if (fill_ok && cs && fill_tag_q == tag) begin
            dout_d    = pick(fill_data, addr[0]);
            ok_r_d    = 1'b1;
            ok_addr_d = addr;
        end
        if (clr) begin
            valid_d = '0;
            ok_r_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fill_tag_q <= '0;
            low_q      <= '0;
            tag_q      <= '0;
            data_q     <= '0;
            valid_q    <= '0;
            victim_q   <= 1'b0;
            poison_q   <= 1'b0;
            ok_r_q     <= 1'b0;
            dout_q     <= '0;
            ok_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            fill_tag_q <= fill_tag_d;
            low_q      <= low_d;
            tag_q      <= tag_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            victim_q   <= victim_d;
            poison_q   <= poison_d;
            ok_r_q     <= ok_r_d;
            dout_q     <= dout_d;
            ok_addr_q  <= ok_addr_d;
        end
    end
endmodule
